// File: rtl/sound_pkg.sv
// Shared sound definitions.
// Holds the sound type enum shared with the game-state FSM, the player state enum,
// the note frequency constants, and the tables mapping a sound to its note sequence.
package sound_pkg;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } soundtype_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } player_state_t;

  // Note frequencies in Hz
  localparam int unsigned FREQ_A3 = 220;
  localparam int unsigned FREQ_E4 = 330;
  localparam int unsigned FREQ_C5 = 523;
  localparam int unsigned FREQ_E5 = 659;
  localparam int unsigned FREQ_G5 = 784;
  localparam int unsigned FREQ_C6 = 1047;

  // Sizes the half-period counter: the lowest note has the longest half period
  localparam int unsigned FREQ_LOWEST = FREQ_A3;

  // Frequency of note idx of a sound. Indices past the end repeat the last note;
  // they are never played but keep every table entry a legal divisor.
  function automatic int unsigned note_freq(soundtype_t sound, logic [1:0] idx);
    int unsigned f;
    f = FREQ_C6;
    case (sound)
      UI_PRESS: f = FREQ_C6;
      NEXTLEVEL: begin
        case (idx)
          2'd0:    f = FREQ_C5;
          2'd1:    f = FREQ_E5;
          default: f = FREQ_G5;
        endcase
      end
      CRASH: f = (idx == 2'd0) ? FREQ_E4 : FREQ_A3;
      CELEBRATION: begin
        case (idx)
          2'd0:    f = FREQ_C5;
          2'd1:    f = FREQ_E5;
          2'd2:    f = FREQ_G5;
          default: f = FREQ_C6;
        endcase
      end
      default: f = FREQ_C6;
    endcase
    return f;
  endfunction

  // Sequence length minus one
  function automatic logic [1:0] seq_last(soundtype_t sound);
    logic [1:0] last;
    last = 2'd0;
    case (sound)
      UI_PRESS:    last = 2'd0;
      NEXTLEVEL:   last = 2'd2;
      CRASH:       last = 2'd1;
      CELEBRATION: last = 2'd3;
      default:     last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sound_player_tone_gen.sv
// Square-wave generator.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   enable       - run the wave; when low the counter clears and wave returns to 0
//   restart      - synchronous clear of counter and wave, wins over enable
//   half_period  - cycles per half period of the wave
//   wave         - square-wave output, 0 on the first cycle after a clear
module tone_gen #(
  parameter int unsigned HP_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            restart,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] count_q;
  logic            wave_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wave_q  <= 1'b0;
    end else if (!enable || restart) begin
      count_q <= '0;
      wave_q  <= 1'b0;
    end else if (count_q == half_period - HP_W'(1)) begin
      count_q <= '0;
      wave_q  <= ~wave_q;
    end else begin
      count_q <= count_q + HP_W'(1);
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/sound_player.sv
// Sound player: plays a fixed square-wave note sequence per requested sound type.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   soundselector  - sound type, latched on a request
//   playsound      - request level; a rising edge starts (or restarts) a sequence
//   mute           - gates the speaker only; sequencing is unaffected
//   speaker        - square-wave audio output
//   busy           - high while a sequence plays, gaps included
//   done           - one-cycle pulse when a sequence completes normally
module sound_player
  import sound_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned NOTE_CYCLES = 1_200_000,
  parameter int unsigned GAP_CYCLES  = 120_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] soundselector,
  input  logic       playsound,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HP_W    = $clog2(CLK_HZ / (2 * FREQ_LOWEST) + 1);
  localparam int unsigned DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);

  // Half-period table indexed by {sound, note}; all entries are elaboration-time constants
  logic [HP_W-1:0] hp_table [16];

  for (genvar g = 0; g < 16; g++) begin : g_hp
    localparam int unsigned FREQ = note_freq(soundtype_t'(2'(g / 4)), 2'(g % 4));
    assign hp_table[g] = HP_W'(CLK_HZ / (2 * FREQ));
  end

  player_state_t    state_q;
  soundtype_t       sel_q;
  logic [1:0]       note_q;
  logic [DUR_W-1:0] dur_q;
  logic             playsound_q;
  logic             busy_q;
  logic             done_q;

  logic             req;
  logic             note_end;
  logic [HP_W-1:0]  hp;
  logic             tone_bit;

  assign req      = playsound & ~playsound_q;
  assign note_end = (state_q == TONE) && (dur_q == NOTE_LAST);
  assign hp       = hp_table[{sel_q, note_q}];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= UI_PRESS;
      note_q      <= 2'd0;
      dur_q       <= '0;
      playsound_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      playsound_q <= playsound;
      done_q      <= 1'b0;
      if (req) begin
        // A request always (re)starts at note 0, aborting any sequence in flight
        sel_q   <= soundtype_t'(soundselector);
        state_q <= TONE;
        note_q  <= 2'd0;
        dur_q   <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          TONE: begin
            if (dur_q == NOTE_LAST) begin
              dur_q <= '0;
              if (note_q == seq_last(sel_q)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= GAP;
              end
            end else begin
              dur_q <= dur_q + DUR_W'(1);
            end
          end
          GAP: begin
            if (dur_q == GAP_LAST) begin
              dur_q   <= '0;
              state_q <= TONE;
              note_q  <= note_q + 2'd1;
            end else begin
              dur_q <= dur_q + DUR_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clearing on note_end keeps the first gap/idle cycle silent instead of
  // carrying one cycle of the last wave value past the note.
  tone_gen #(
    .HP_W(HP_W)
  ) u_tone_gen (
    .clk        (clk),
    .reset      (reset),
    .enable     (state_q == TONE),
    .restart    (req | note_end),
    .half_period(hp),
    .wave       (tone_bit)
  );

  assign speaker = tone_bit & ~mute;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
